// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate pong sequencer: scoring, serve ownership, ball direction, beeps
// Optional feature macro: PONG_AUTOSERVE_EN (serve automatically after AUTOSERVE_FRAMES idle frames)
module pong_game_ctrl #(
    parameter int         WIN_SCORE        = 7,
    parameter int         SCORE_W          = 4,
    parameter logic [9:0] X_MIN            = 10'd8,
    parameter logic [9:0] X_MAX            = 10'd624,
    parameter int         POINT_FRAMES     = 60,
    parameter int         BEEP_FRAMES      = 8,
    parameter int         AUTOSERVE_FRAMES = 180
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [9:0]         ball_x,
    input  logic               p1_srv,
    input  logic               p2_srv,
    input  logic               p1_hit,
    input  logic               p2_hit,
    output logic               ball_run,
    output logic               ball_dir,
    output logic               ball_reset,
    output logic [1:0]         serve_side,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         state,
    output logic               game_over,
    output logic               winner,
    output logic               beep_lo,
    output logic               beep_hi
);
    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_RALLY = 2'd1,
        S_POINT = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int PAUSE_W = $clog2(POINT_FRAMES + 1);
    localparam int BEEP_W  = $clog2(2 * BEEP_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(POINT_FRAMES);
    localparam logic [BEEP_W-1:0]  BEEP_SHORT = BEEP_W'(BEEP_FRAMES);
    localparam logic [BEEP_W-1:0]  BEEP_LONG  = BEEP_W'(2 * BEEP_FRAMES);

    state_t               st_q, st_d;
    logic [1:0]           side_q, side_d;
    logic [SCORE_W-1:0]   sc1_q, sc1_d, sc2_q, sc2_d;
    logic                 run_q, run_d, dir_q, dir_d, brst_q, brst_d;
    logic                 win_q, win_d, scorer_q, scorer_d;
    logic                 prev1_q, prev2_q;
    logic [PAUSE_W-1:0]   pause_q, pause_d;
    logic [BEEP_W-1:0]    beep_cnt_q, beep_cnt_d;
    logic                 tone_hi_q, tone_hi_d;
    logic                 auto_fire;

`ifdef PONG_AUTOSERVE_EN
    localparam int AUTO_W = $clog2(AUTOSERVE_FRAMES + 1);
    logic [AUTO_W-1:0] auto_q, auto_d;
    assign auto_fire = frame_tick && (auto_q == AUTO_W'(AUTOSERVE_FRAMES - 1));
`else
    assign auto_fire = (AUTOSERVE_FRAMES < 0);
`endif

    always_comb begin
        st_d       = st_q;
        side_d     = side_q;
        sc1_d      = sc1_q;
        sc2_d      = sc2_q;
        run_d      = run_q;
        dir_d      = dir_q;
        brst_d     = 1'b0;
        win_d      = win_q;
        scorer_d   = scorer_q;
        pause_d    = pause_q;
        tone_hi_d  = tone_hi_q;
        beep_cnt_d = (frame_tick && beep_cnt_q != '0) ? beep_cnt_q - BEEP_W'(1) : beep_cnt_q;

        case (st_q)
            S_SERVE: begin
                // Serve direction follows ownership: P1 serves rightwards, P2 leftwards
                if ((p1_srv && side_q[1]) || (p2_srv && side_q[0]) || auto_fire) begin
                    st_d   = S_RALLY;
                    dir_d  = side_q[1];
                    side_d = 2'b00;
                    run_d  = 1'b1;
                end
            end
            S_RALLY: begin
                if (frame_tick) begin
                    if (p1_hit && !dir_q) begin
                        dir_d      = 1'b1;
                        tone_hi_d  = 1'b0;
                        beep_cnt_d = BEEP_SHORT;
                    end else if (p2_hit && dir_q) begin
                        dir_d      = 1'b0;
                        tone_hi_d  = 1'b1;
                        beep_cnt_d = BEEP_SHORT;
                    end else if ((ball_x <= X_MIN && !dir_q) || (ball_x >= X_MAX && dir_q)) begin
                        if (dir_q) begin
                            sc1_d = (sc1_q == WIN_S) ? sc1_q : sc1_q + SCORE_W'(1);
                        end else begin
                            sc2_d = (sc2_q == WIN_S) ? sc2_q : sc2_q + SCORE_W'(1);
                        end
                        scorer_d   = !dir_q;
                        st_d       = S_POINT;
                        run_d      = 1'b0;
                        pause_d    = PAUSE_LOAD;
                        tone_hi_d  = 1'b0;
                        beep_cnt_d = BEEP_LONG;
                    end
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (pause_q != '0) begin
                        pause_d = pause_q - PAUSE_W'(1);
                    end else if ((scorer_q ? sc2_q : sc1_q) == WIN_S) begin
                        st_d  = S_OVER;
                        win_d = scorer_q;
                    end else begin
                        st_d   = S_SERVE;
                        brst_d = 1'b1;
                        side_d = scorer_q ? 2'b10 : 2'b01;
                    end
                end
            end
            S_OVER: begin
                if ((p1_srv && !prev1_q) || (p2_srv && !prev2_q)) begin
                    st_d   = S_SERVE;
                    sc1_d  = '0;
                    sc2_d  = '0;
                    win_d  = 1'b0;
                    side_d = 2'b01;
                    brst_d = 1'b1;
                end
            end
            default: st_d = S_SERVE;
        endcase

`ifdef PONG_AUTOSERVE_EN
        auto_d = (st_q == S_SERVE && st_d == S_SERVE) ? auto_q + AUTO_W'(frame_tick) : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= S_SERVE;
            side_q     <= 2'b01;
            sc1_q      <= '0;
            sc2_q      <= '0;
            run_q      <= 1'b0;
            dir_q      <= 1'b0;
            brst_q     <= 1'b0;
            win_q      <= 1'b0;
            scorer_q   <= 1'b0;
            prev1_q    <= 1'b0;
            prev2_q    <= 1'b0;
            pause_q    <= '0;
            beep_cnt_q <= '0;
            tone_hi_q  <= 1'b0;
`ifdef PONG_AUTOSERVE_EN
            auto_q     <= '0;
`endif
        end else begin
            st_q       <= st_d;
            side_q     <= side_d;
            sc1_q      <= sc1_d;
            sc2_q      <= sc2_d;
            run_q      <= run_d;
            dir_q      <= dir_d;
            brst_q     <= brst_d;
            win_q      <= win_d;
            scorer_q   <= scorer_d;
            prev1_q    <= p1_srv;
            prev2_q    <= p2_srv;
            pause_q    <= pause_d;
            beep_cnt_q <= beep_cnt_d;
            tone_hi_q  <= tone_hi_d;
`ifdef PONG_AUTOSERVE_EN
            auto_q     <= auto_d;
`endif
        end
    end

    assign ball_run   = run_q;
    assign ball_dir   = dir_q;
    assign ball_reset = brst_q;
    assign serve_side = side_q;
    assign score_p1   = sc1_q;
    assign score_p2   = sc2_q;
    assign state      = st_q;
    assign game_over  = (st_q == S_OVER);
    assign winner     = win_q;
    assign beep_lo    = (beep_cnt_q != '0) && !tone_hi_q;
    assign beep_hi    = (beep_cnt_q != '0) && tone_hi_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl with a frame-count reference model
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] ball_x = 10'd300;
    logic       p1_srv = 1'b0, p2_srv = 1'b0, p1_hit = 1'b0, p2_hit = 1'b0;
    logic       ball_run, ball_dir, ball_reset, game_over, winner, beep_lo, beep_hi;
    logic [1:0] serve_side, state;
    logic [3:0] score_p1, score_p2;

    int checks = 0;
    int errors = 0;

    pong_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .ball_x(ball_x),
        .p1_srv(p1_srv), .p2_srv(p2_srv), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .ball_run(ball_run), .ball_dir(ball_dir), .ball_reset(ball_reset),
        .serve_side(serve_side), .score_p1(score_p1), .score_p2(score_p2),
        .state(state), .game_over(game_over), .winner(winner),
        .beep_lo(beep_lo), .beep_hi(beep_hi)
    );

    always #5 clk = ~clk;

    // Reference model: game rules expressed with frame indices rather than down-counters
    int mst, mside, ms1, ms2, mrun, mdir, mbrst, mwin, mscorer, mprev1, mprev2;
    int mframe = 0;
    int mpoint_frame, mbeep_end, mtone, mauto;

    task automatic model_reset();
        mst = 0; mside = 1; ms1 = 0; ms2 = 0; mrun = 0; mdir = 0; mbrst = 0;
        mwin = 0; mscorer = 0; mprev1 = 0; mprev2 = 0; mbeep_end = -1; mtone = 0;
        mpoint_frame = 0; mauto = 0;
    endtask

    task automatic model_step(input int tk, input int x, input int s1, input int s2,
                              input int h1, input int h2);
        int f = mframe;
        int go1, go2;
        mbrst = 0;
        if (mst == 0) begin
            go1 = (s1 != 0 && mside == 2);
            go2 = (s2 != 0 && mside == 1);
`ifdef PONG_AUTOSERVE_EN
            if (tk != 0) mauto++;
            if (mauto >= 180) begin go1 = (mside == 2); go2 = (mside == 1); end
`endif
            if (go1 != 0 || go2 != 0) begin
                mst = 1; mdir = go1; mside = 0; mrun = 1; mauto = 0;
            end
        end else if (mst == 1 && tk != 0) begin
            if (h1 != 0 && mdir == 0) begin
                mdir = 1; mtone = 0; mbeep_end = f + 8;
            end else if (h2 != 0 && mdir == 1) begin
                mdir = 0; mtone = 1; mbeep_end = f + 8;
            end else if ((x <= 8 && mdir == 0) || (x >= 624 && mdir == 1)) begin
                mscorer = (mdir == 0) ? 1 : 0;
                if (mscorer == 0) ms1 = (ms1 < 7) ? ms1 + 1 : 7;
                else ms2 = (ms2 < 7) ? ms2 + 1 : 7;
                mst = 2; mrun = 0; mpoint_frame = f; mtone = 0; mbeep_end = f + 16;
            end
        end else if (mst == 2 && tk != 0 && f == mpoint_frame + 61) begin
            if ((mscorer == 0 ? ms1 : ms2) == 7) begin
                mst = 3; mwin = mscorer;
            end else begin
                mst = 0; mbrst = 1; mside = (mscorer == 0) ? 1 : 2;
            end
        end else if (mst == 3 && ((s1 != 0 && mprev1 == 0) || (s2 != 0 && mprev2 == 0))) begin
            mst = 0; ms1 = 0; ms2 = 0; mwin = 0; mside = 1; mbrst = 1;
        end
        if (tk != 0) mframe++;
        mprev1 = s1; mprev2 = s2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        int on;
        on = (mframe <= mbeep_end) ? 1 : 0;
        chk("state", 32'(state), mst);
        chk("serve_side", 32'(serve_side), mside);
        chk("score_p1", 32'(score_p1), ms1);
        chk("score_p2", 32'(score_p2), ms2);
        chk("ball_run", 32'(ball_run), mrun);
        chk("ball_dir", 32'(ball_dir), mdir);
        chk("ball_reset", 32'(ball_reset), mbrst);
        chk("game_over", 32'(game_over), (mst == 3) ? 1 : 0);
        chk("winner", 32'(winner), mwin);
        chk("beep_lo", 32'(beep_lo), (on != 0 && mtone == 0) ? 1 : 0);
        chk("beep_hi", 32'(beep_hi), (on != 0 && mtone == 1) ? 1 : 0);
    endtask

    task automatic cyc(input int tk, input int x, input int s1, input int s2,
                       input int h1, input int h2);
        frame_tick = 1'(tk); ball_x = 10'(x);
        p1_srv = 1'(s1); p2_srv = 1'(s2); p1_hit = 1'(h1); p2_hit = 1'(h2);
        model_step(tk, x, s1, s2, h1, h2);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 300, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic       tk;
        logic [9:0] x;
        logic       s1, s2, h1, h2;
        logic [1:0] st;
        logic       run, dir;
        logic [1:0] side;
        logic       blo, bhi;
        logic [3:0] sp2;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{1'b0, 10'd300, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0};
        vt[1]  = '{1'b1, 10'd300, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0};
        vt[2]  = '{1'b1, 10'd300, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0};
        vt[3]  = '{1'b0, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0};
        for (int i = 4; i < 10; i++)
            vt[i] = '{1'b1, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0};
        vt[10] = '{1'b1, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'd0};
        vt[11] = '{1'b1, 10'd300, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0};
        vt[12] = '{1'b1, 10'd5,   1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp_model();
        chk("rst_serve_side", 32'(serve_side), 1);
        chk("rst_state", 32'(state), 0);
        rst_n = 1'b1;

        // Serve, paddle bounce, beep decay, opposite paddle, P2 point
        for (int i = 0; i < 13; i++) begin
            cyc(int'(vt[i].tk), int'(vt[i].x), int'(vt[i].s1), int'(vt[i].s2),
                int'(vt[i].h1), int'(vt[i].h2));
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("tbl%0d_run", i), 32'(ball_run), 32'(vt[i].run));
            chk($sformatf("tbl%0d_dir", i), 32'(ball_dir), 32'(vt[i].dir));
            chk($sformatf("tbl%0d_side", i), 32'(serve_side), 32'(vt[i].side));
            chk($sformatf("tbl%0d_beep_lo", i), 32'(beep_lo), 32'(vt[i].blo));
            chk($sformatf("tbl%0d_beep_hi", i), 32'(beep_hi), 32'(vt[i].bhi));
            chk($sformatf("tbl%0d_score_p2", i), 32'(score_p2), 32'(vt[i].sp2));
        end

        // Point pause: 60 ticks still paused, 61st returns to SERVE with P1 to serve
        ticks(60);
        chk("pause_state", 32'(state), 2);
        ticks(1);
        chk("post_point_state", 32'(state), 0);
        chk("post_point_reset", 32'(ball_reset), 1);
        chk("post_point_side", 32'(serve_side), 2);
        cyc(0, 300, 0, 0, 0, 0);
        chk("reset_pulse_width", 32'(ball_reset), 0);

        // Non-serving P2 button ignored; P1 serves; hit beats out-of-bounds on the same tick
        cyc(0, 300, 0, 1, 0, 0);
        chk("wrong_server_state", 32'(state), 0);
        cyc(0, 300, 1, 1, 0, 0);
        chk("p1_serve_dir", 32'(ball_dir), 1);
        cyc(1, 630, 0, 0, 0, 1);
        chk("hit_wins_dir", 32'(ball_dir), 0);
        chk("hit_wins_beep_hi", 32'(beep_hi), 1);
        chk("hit_wins_score", 32'(score_p1), 0);
        chk("hit_wins_state", 32'(state), 1);

        // P1 runs up the score to the win
        for (int k = 0; k < 7; k++) begin
            cyc(1, 300, 0, 0, 1, 0);
            cyc(1, 630, 0, 0, 0, 0);
            if (k < 6) begin
                ticks(61);
                cyc(0, 300, 0, 1, 0, 0);
            end
        end
        chk("win_score_p1", 32'(score_p1), 7);
        ticks(61);
        chk("over_state", 32'(state), 3);
        chk("over_game_over", 32'(game_over), 1);
        chk("over_winner", 32'(winner), 0);
        chk("over_no_reset", 32'(ball_reset), 0);
        cyc(0, 300, 0, 1, 0, 0);
        chk("restart_state", 32'(state), 0);
        chk("restart_score_p1", 32'(score_p1), 0);
        chk("restart_side", 32'(serve_side), 1);
        chk("restart_reset", 32'(ball_reset), 1);
        cyc(0, 300, 0, 0, 0, 0);

        // Asynchronous reset between clock edges during a rally
        cyc(0, 300, 0, 1, 0, 0);
        cyc(1, 300, 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_side", 32'(serve_side), 1);
        chk("async_run", 32'(ball_run), 0);
        chk("async_dir", 32'(ball_dir), 0);
        chk("async_beep_lo", 32'(beep_lo), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef PONG_AUTOSERVE_EN
        ticks(179);
        chk("auto_wait_state", 32'(state), 0);
        ticks(1);
        chk("auto_serve_state", 32'(state), 1);
`endif

        // Randomised play against the model, edge positions weighted
        for (int i = 0; i < 20000; i++) begin
            int x;
            case ($urandom_range(0, 7))
                0: x = 7;
                1: x = 8;
                2: x = 623;
                3: x = 624;
                4: x = $urandom_range(0, 12);
                5: x = $urandom_range(620, 639);
                default: x = $urandom_range(0, 639);
            endcase
            cyc(($urandom_range(0, 2) == 0) ? 1 : 0, x,
                ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
                ($urandom_range(0, 5) == 0) ? 1 : 0, ($urandom_range(0, 5) == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
